// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Optional return stack is enabled by defining PC_STACK_EN.
package pc_pkg;

  localparam int PC_ADDR_W      = 8;
  localparam int PC_OFFS_W      = 8;
  localparam int PC_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_UP,
    OP_RET,
    OP_CALL,
    OP_BRANCH,
    OP_LOAD,
    OP_CLEAR
  } pc_op_e;

  // Fixed-priority request decode: clear > load > branch > call > ret > up > hold.
  function automatic pc_op_e decode_op(input logic clear, input logic load,
                                       input logic branch, input logic call,
                                       input logic ret, input logic up);
    pc_op_e op;
    if (clear)       op = OP_CLEAR;
    else if (load)   op = OP_LOAD;
    else if (branch) op = OP_BRANCH;
    else if (call)   op = OP_CALL;
    else if (ret)    op = OP_RET;
    else if (up)     op = OP_UP;
    else             op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_sequencer_stack.sv
// Return-address LIFO for the sequencer. Count is registered, so full/empty
// follow a push or pop by one edge. Overflowing pushes and underflowing pops
// are ignored here; the caller flags them.
module pc_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear && !push;
  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);
  assign data_out = mem_q[top_idx];

  // Entry count: clear wins, then push, then pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (push_ok) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop_ok) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset; entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, absolute load, relative branch and,
// when PC_STACK_EN is defined, call/return through a small return stack.
// Without PC_STACK_EN, call and ret still win priority but act as hold.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W      = PC_ADDR_W,
  parameter int OFFS_W      = PC_OFFS_W,
  parameter int STACK_DEPTH = PC_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              up,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              branch,
  input  logic [OFFS_W-1:0] offset,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] address,
  output logic              wrapped,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  if (ADDR_W < 2 || OFFS_W > ADDR_W || STACK_DEPTH < 2 ||
      (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_param_check
    $error("pc_sequencer: illegal parameter combination");
  end

  logic [ADDR_W-1:0] address_q;
  logic              wrapped_q;
  logic              stack_err_q;
  logic [ADDR_W-1:0] offs_ext;
  logic [ADDR_W-1:0] st_top;
  logic              st_full;
  logic              st_empty;
  pc_op_e            op;

  // Winning request for this cycle.
  always_comb begin
    op = decode_op(clear, load, branch, call, ret, up);
  end

  assign offs_ext = ADDR_W'($signed(offset));

`ifdef PC_STACK_EN
  localparam bit STACK_EN = 1'b1;

  pc_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (op == OP_CLEAR),
    .push     ((op == OP_CALL) && !st_full),
    .pop      ((op == OP_RET) && !st_empty),
    .data_in  (address_q + ADDR_W'(1)),
    .data_out (st_top),
    .full     (st_full),
    .empty    (st_empty)
  );
`else
  localparam bit STACK_EN = 1'b0;

  assign st_top   = '0;
  assign st_full  = 1'b0;
  assign st_empty = 1'b1;
`endif

  // Address update plus the one-cycle wrapped/stack_err pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q   <= '0;
      wrapped_q   <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      wrapped_q   <= 1'b0;
      stack_err_q <= 1'b0;
      case (op)
        OP_CLEAR:  address_q <= '0;
        OP_LOAD:   address_q <= load_addr;
        OP_BRANCH: address_q <= address_q + offs_ext;
        OP_CALL: begin
          if (STACK_EN) begin
            if (st_full) stack_err_q <= 1'b1;
            else         address_q   <= load_addr;
          end
        end
        OP_RET: begin
          if (STACK_EN) begin
            if (st_empty) stack_err_q <= 1'b1;
            else          address_q   <= st_top;
          end
        end
        OP_UP: begin
          address_q <= address_q + ADDR_W'(1);
          wrapped_q <= &address_q;
        end
        default: ;
      endcase
    end
  end

  assign address     = address_q;
  assign wrapped     = wrapped_q;
  assign stack_err   = stack_err_q;
  assign stack_full  = st_full;
  assign stack_empty = st_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with default parameters.
// Expected values follow the build: with PC_STACK_EN the stack is exercised,
// without it call/ret must behave as hold with fixed stack flags.
module tb_pc_sequencer;

`ifdef PC_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0, up = 1'b0, load = 1'b0, branch = 1'b0;
  logic       call = 1'b0, ret = 1'b0;
  logic [7:0] load_addr = 8'h00, offset = 8'h00;
  logic [7:0] address;
  logic       wrapped, stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic       wr;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .up          (up),
    .load        (load),
    .load_addr   (load_addr),
    .branch      (branch),
    .offset      (offset),
    .call        (call),
    .ret         (ret),
    .address     (address),
    .wrapped     (wrapped),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_now(input string nm, input logic [7:0] ea, input logic ew,
                           input logic ef, input logic ee, input logic eerr);
    checks++;
    if (address !== ea || wrapped !== ew || stack_full !== ef ||
        stack_empty !== ee || stack_err !== eerr) begin
      errors++;
      $display("FAIL %s: got addr=%h wr=%b full=%b empty=%b err=%b, expected addr=%h wr=%b full=%b empty=%b err=%b",
               nm, address, wrapped, stack_full, stack_empty, stack_err,
               ea, ew, ef, ee, eerr);
    end
  endtask

  // Monitor: every edge the DUT presents a new state; compare it against the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_now(e.name, e.addr, e.wr, e.full, e.empty, e.err);
      end
    end
  end

  // One cycle of stimulus; the expectation is for the state after the next edge.
  task automatic vec(input string nm, input logic c_clr, input logic c_ld,
                     input logic c_br, input logic c_call, input logic c_ret,
                     input logic c_up, input logic [7:0] la, input logic [7:0] off,
                     input logic [7:0] ea, input logic ew, input logic ef,
                     input logic ee, input logic eerr);
    exp_t e;
    @(negedge clk);
    clear = c_clr; load = c_ld; branch = c_br; call = c_call; ret = c_ret;
    up = c_up; load_addr = la; offset = off;
    e.name = nm; e.addr = ea; e.wr = ew; e.full = ef; e.empty = ee; e.err = eerr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [7:0] ea, input logic ee);
    vec(nm, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, ea, 1'b0, 1'b0, ee, 1'b0);
  endtask

  initial begin
    // Reset state, checked with no clock edge yet.
    #3;
    check_now("reset_state", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Increment across the full range; wrapped only on the 255->0 step.
    for (int i = 0; i < 256; i++) begin
      vec("up_count", 0, 0, 0, 0, 0, 1, 8'h00, 8'h00,
          8'((i + 1) % 256), (i == 255), 1'b0, 1'b1, 1'b0);
    end
    idle("after_wrap_hold", 8'h00, 1'b1);

    // Relative branches, including one that overflows without flagging wrap.
    vec("load_10", 0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 1, 0);
    vec("branch_m16", 0, 0, 1, 0, 0, 0, 8'h00, 8'hF0, 8'h00, 0, 0, 1, 0);
    vec("branch_p5", 0, 0, 1, 0, 0, 0, 8'h00, 8'h05, 8'h05, 0, 0, 1, 0);
    vec("load_ff", 0, 1, 0, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 0, 0, 1, 0);
    vec("branch_ovf", 0, 0, 1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 1, 0);

    // Single call and return.
    vec("load_20", 0, 1, 0, 0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 0, 1, 0);
    vec("call_80", 0, 0, 0, 1, 0, 0, 8'h80, 8'h00, EN ? 8'h80 : 8'h20, 0, 0, !EN, 0);
    vec("ret_21", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, EN ? 8'h21 : 8'h20, 0, 0, 1, 0);

    // Fill the stack, overflow, drain, underflow.
    vec("load_00", 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
    vec("call1", 0, 0, 0, 1, 0, 0, 8'h10, 8'h00, EN ? 8'h10 : 8'h00, 0, 0, !EN, 0);
    vec("call2", 0, 0, 0, 1, 0, 0, 8'h20, 8'h00, EN ? 8'h20 : 8'h00, 0, 0, !EN, 0);
    vec("call3", 0, 0, 0, 1, 0, 0, 8'h30, 8'h00, EN ? 8'h30 : 8'h00, 0, 0, !EN, 0);
    vec("call4_full", 0, 0, 0, 1, 0, 0, 8'h40, 8'h00, EN ? 8'h40 : 8'h00, 0, EN, !EN, 0);
    vec("call5_overflow", 0, 0, 0, 1, 0, 0, 8'h50, 8'h00, EN ? 8'h40 : 8'h00, 0, EN, !EN, EN);
    vec("err_pulse_end", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, EN ? 8'h40 : 8'h00, 0, EN, !EN, 0);
    vec("ret4", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, EN ? 8'h31 : 8'h00, 0, 0, !EN, 0);
    vec("ret3", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, EN ? 8'h21 : 8'h00, 0, 0, !EN, 0);
    vec("ret2", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, EN ? 8'h11 : 8'h00, 0, 0, !EN, 0);
    vec("ret1_empty", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, EN ? 8'h01 : 8'h00, 0, 0, 1, 0);
    vec("ret_underflow", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, EN ? 8'h01 : 8'h00, 0, 0, 1, EN);

    // Priority between simultaneous requests.
    vec("load_33", 0, 1, 0, 0, 0, 0, 8'h33, 8'h00, 8'h33, 0, 0, 1, 0);
    vec("clr_ld_up", 1, 1, 0, 0, 0, 1, 8'h77, 8'h00, 8'h00, 0, 0, 1, 0);
    vec("ld_up", 0, 1, 0, 0, 0, 1, 8'h5A, 8'h00, 8'h5A, 0, 0, 1, 0);
    vec("load_10b", 0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0, 1, 0);
    vec("br_call_ret", 0, 0, 1, 1, 1, 0, 8'h99, 8'h02, 8'h12, 0, 0, 1, 0);
    vec("ret_up_empty", 0, 0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h12, 0, 0, 1, EN);
    vec("call_40", 0, 0, 0, 1, 0, 0, 8'h40, 8'h00, EN ? 8'h40 : 8'h12, 0, 0, !EN, 0);
    vec("clear_stack", 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);

    // Two stacked entries and address 0x42, then an asynchronous reset.
    vec("load_40", 0, 1, 0, 0, 0, 0, 8'h40, 8'h00, 8'h40, 0, 0, 1, 0);
    vec("callA", 0, 0, 0, 1, 0, 0, 8'h10, 8'h00, EN ? 8'h10 : 8'h40, 0, 0, !EN, 0);
    vec("callB", 0, 0, 0, 1, 0, 0, 8'h42, 8'h00, EN ? 8'h42 : 8'h40, 0, 0, !EN, 0);
    vec("load_42", 0, 1, 0, 0, 0, 0, 8'h42, 8'h00, 8'h42, 0, 0, !EN, 0);
    @(posedge clk);
    #2;
    clear = 0; load = 0; branch = 0; up = 0; ret = 0;
    call = 1'b1; load_addr = 8'h77;
    reset_n = 1'b0;
    #1;
    check_now("async_reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_now("reset_held_edge", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    call = 1'b0;
    reset_n = 1'b1;
    idle("post_reset_hold", 8'h00, 1'b1);
    vec("post_reset_ret", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, EN);
    idle("final_hold", 8'h00, 1'b1);

    // Let the monitor drain; anything left over is a missed comparison.
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width in bits (>=2).
REQ-002 SHALL have parameter OFFS_W, default 8, meaning signed branch-offset width (<=ADDR_W).
REQ-003 SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous clear.
REQ-007 SHALL have port up  input  1  increment request.
REQ-008 SHALL have port load  input  1  absolute jump request.
REQ-009 SHALL have port load_addr  input  ADDR_W  jump/call target.
REQ-010 SHALL have port branch  input  1  relative branch request.
REQ-011 SHALL have port offset  input  OFFS_W  signed two's-complement branch offset.
REQ-012 SHALL have port call  input  1  subroutine call request.
REQ-013 SHALL have port ret  input  1  subroutine return request.
REQ-014 SHALL have port address  output  ADDR_W  current program address, registered.
REQ-015 SHALL have port wrapped  output  1  one-cycle pulse on increment wrap.
REQ-016 SHALL have port stack_full  output  1  return stack holds STACK_DEPTH entries.
REQ-017 SHALL have port stack_empty  output  1  return stack holds zero entries.
REQ-018 SHALL have port stack_err  output  1  one-cycle pulse on call-when-full or ret-when-empty.

Function
REQ-019 SHALL decode requests each cycle with fixed priority: clear > load > branch > call > ret > up > hold; only the winning operation takes effect.
REQ-020 SHALL on clear set address to 0 and empty the stack at the next edge.
REQ-021 SHALL on load set address to load_addr at the next edge.
REQ-022 SHALL on branch set address to address + sign-extended offset, modulo 2^ADDR_W.
REQ-023 SHALL on call (stack not full) push address+1 (mod 2^ADDR_W) and set address to load_addr.
REQ-024 SHALL on call with stack full leave address and stack unchanged and assert stack_err for one cycle.
REQ-025 SHALL on ret (stack not empty) pop the top entry into address.
REQ-026 SHALL on ret with stack empty leave address unchanged and assert stack_err for one cycle.
REQ-027 SHALL on up set address to address+1, wrapping all-ones to 0 and asserting wrapped for exactly that following cycle.
REQ-028 SHALL not assert wrapped on branch, load, call or ret, even if the arithmetic overflows.
REQ-029 SHALL hold address when no request is active.
REQ-030 SHALL derive stack_full and stack_empty from the registered stack count, updated with one-cycle latency after push/pop.

Reset
REQ-031 SHALL on reset_n low immediately force address=0, stack count=0, wrapped=0, stack_err=0, stack_empty=1, stack_full=0, regardless of clk.
REQ-032 SHALL resume normal decoding on the first rising edge after reset_n deasserts; an in-flight call/ret during reset is discarded.

Configuration
REQ-033 SHALL compile the return stack only when macro PC_STACK_EN is defined.
REQ-034 SHALL without PC_STACK_EN ignore call and ret (treated as hold when winning), tie stack_full=0, stack_empty=1, stack_err=0, keeping all ports present.

Structure
REQ-035 SHALL place in package pc_pkg: enum pc_op_e {OP_HOLD, OP_UP, OP_RET, OP_CALL, OP_BRANCH, OP_LOAD, OP_CLEAR} and default-parameter constants.
REQ-036 SHALL implement the LIFO as sub-module pc_stack (push, pop, clear, data_in, data_out, full, empty).

Verification
REQ-037 SHALL cover: reset, up held 256 cycles (ADDR_W=8) -> address 0..255 then 0, wrapped high exactly one cycle at the 255->0 transition.
REQ-038 SHALL cover: address=0x10, branch offset=8'hF0 -> address 0x00; offset=8'h05 -> 0x05; wrapped stays 0.
REQ-039 SHALL cover: address=0x20, call load_addr=0x80 -> address 0x80, stack_empty 0; ret -> address 0x21, stack_empty 1.
REQ-040 SHALL cover: four calls fill stack (stack_full=1); fifth call -> stack_err pulse, address unchanged; ret on empty -> stack_err pulse.
REQ-041 SHALL cover: clear, load and up asserted together -> address 0; load and up together -> load_addr.
REQ-042 SHALL cover: reset_n pulsed low mid-cycle with address=0x42 and two stacked entries -> address 0 and stack_empty 1 before next clk edge.
